// File: rtl/idct_pkg.sv
// Shared widths, HEVC coefficient constants and arithmetic helpers
// for the IDCT row element.
package idct_pkg;

  localparam int IDCT_N      = 8;
  localparam int IDCT_IN_W   = 16;
  localparam int IDCT_COEF_W = 8;
  localparam int IDCT_ACC_W  = 32;
  localparam int IDCT_OUT_W  = 16;

  localparam logic signed [7:0] HEVC_C64 = 8'sd64;
  localparam logic signed [7:0] HEVC_C83 = 8'sd83;
  localparam logic signed [7:0] HEVC_C36 = 8'sd36;
  localparam logic signed [7:0] HEVC_C89 = 8'sd89;
  localparam logic signed [7:0] HEVC_C75 = 8'sd75;
  localparam logic signed [7:0] HEVC_C50 = 8'sd50;
  localparam logic signed [7:0] HEVC_C18 = 8'sd18;

  function automatic logic signed [63:0] idct_rnd(
    input logic [5:0] s
  );
    if (s == 6'd0) return 64'sd0;
    return 64'sd1 <<< (s - 6'd1);
  endfunction

  function automatic logic signed [63:0] idct_clip(
    input logic signed [63:0] v,
    input int                 w
  );
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/idct_mac_row_skew.sv
// Enabled shift register of depth D; aligns one tap's
// {sample, coef} with its accumulator stage.
module idct_skew_line #(
  parameter int D = 1,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [W-1:0] r [D];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < D; i++) r[i] <= '0;
    end else if (en) begin
      r[0] <= din;
      for (int i = 1; i < D; i++) r[i] <= r[i-1];
    end
  end

  assign dout = r[D-1];

endmodule

// File: rtl/idct_mac_row.sv
// Systolic N-tap IDCT row MAC: skewed taps, adder chain,
// then round / arithmetic shift / saturate.
module idct_mac_row
  import idct_pkg::*;
#(
  parameter int N      = IDCT_N,
  parameter int IN_W   = IDCT_IN_W,
  parameter int COEF_W = IDCT_COEF_W,
  parameter int ACC_W  = IDCT_ACC_W,
  parameter int OUT_W  = IDCT_OUT_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en,
  input  logic                   in_valid,
  input  logic [N*IN_W-1:0]      d_in,
  input  logic [N*COEF_W-1:0]    coef,
  input  logic [5:0]             shift,
  output logic                   out_valid,
  output logic [OUT_W-1:0]       d_out,
  output logic                   out_sat,
  output logic                   prop_valid,
  output logic [N*IN_W-1:0]      d_prop
);

  localparam int PW = IN_W + COEF_W;

  logic                    in_v;
  logic [5:0]              in_sh;
  logic signed [ACC_W-1:0] prod [N];
  logic signed [ACC_W-1:0] acc  [N];
  logic                    v    [N];
  logic [5:0]              sh   [N];

  for (genvar k = 0; k < N; k++) begin : g_tap
    logic [PW-1:0]        tap;
    logic [IN_W-1:0]      s;
    logic [COEF_W-1:0]    c;
    logic signed [PW-1:0] p;

    // depth k+1: the first register is the input capture
    idct_skew_line #(.D(k + 1), .W(PW)) u_skew (
      .clk   (clk),
      .reset (reset),
      .en    (en),
      .din   ({d_in[k*IN_W +: IN_W], coef[k*COEF_W +: COEF_W]}),
      .dout  (tap)
    );

    assign s = tap[PW-1:COEF_W];
    assign c = tap[COEF_W-1:0];
    assign p = $signed({{COEF_W{s[IN_W-1]}}, s})
             * $signed({{IN_W{c[COEF_W-1]}}, c});
    assign prod[k] = {{(ACC_W-PW){p[PW-1]}}, p};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      in_v  <= 1'b0;
      in_sh <= '0;
      for (int k = 0; k < N; k++) begin
        acc[k] <= '0;
        v[k]   <= 1'b0;
        sh[k]  <= '0;
      end
    end else if (en) begin
      in_v   <= in_valid;
      in_sh  <= shift;
      acc[0] <= prod[0];
      v[0]   <= in_v;
      sh[0]  <= in_sh;
      for (int k = 1; k < N; k++) begin
        acc[k] <= acc[k-1] + prod[k];
        v[k]   <= v[k-1];
        sh[k]  <= sh[k-1];
      end
    end
  end

  logic signed [63:0] wide;
  logic signed [63:0] rsum;
  logic signed [63:0] shifted;
  logic signed [63:0] clipped;

  // 64-bit headroom so the rounding add never wraps
  always_comb begin
    wide    = {{(64-ACC_W){acc[N-1][ACC_W-1]}}, acc[N-1]};
    rsum    = wide + idct_rnd(sh[N-1]);
    shifted = rsum >>> sh[N-1];
    clipped = idct_clip(shifted, OUT_W);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid  <= 1'b0;
      d_out      <= '0;
      out_sat    <= 1'b0;
      prop_valid <= 1'b0;
      d_prop     <= '0;
    end else if (en) begin
      out_valid  <= v[N-1];
      prop_valid <= in_valid;
      d_prop     <= d_in;
      if (v[N-1]) begin
        d_out   <= clipped[OUT_W-1:0];
        out_sat <= (clipped != shifted);
      end
    end
  end

endmodule

// File: tb/tb_idct_mac_row.sv
// Scoreboard bench for idct_mac_row: directed rows pushed with
// expected results; a negedge monitor pops and compares.
module tb_idct_mac_row;

  localparam int N = 8;
  localparam int IN_W = 16;
  localparam int COEF_W = 8;
  localparam int ACC_W = 32;
  localparam int OUT_W = 16;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 en;
  logic                 in_valid;
  logic [N*IN_W-1:0]    d_in;
  logic [N*COEF_W-1:0]  coef;
  logic [5:0]           shift;
  logic                 out_valid;
  logic [OUT_W-1:0]     d_out;
  logic                 out_sat;
  logic                 prop_valid;
  logic [N*IN_W-1:0]    d_prop;

  idct_mac_row #(
    .N(N), .IN_W(IN_W), .COEF_W(COEF_W), .ACC_W(ACC_W), .OUT_W(OUT_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .in_valid   (in_valid),
    .d_in       (d_in),
    .coef       (coef),
    .shift      (shift),
    .out_valid  (out_valid),
    .d_out      (d_out),
    .out_sat    (out_sat),
    .prop_valid (prop_valid),
    .d_prop     (d_prop)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] d;
    logic        s;
    int          due;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   ecount = 0;
  bit   en_last = 1'b0;
  bit   rst_last = 1'b1;
  logic        pv = 1'b0;
  logic [15:0] pd = '0;

  task automatic chk(input string name, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  // en-high edge counter gives latency in advancing cycles
  always @(posedge clk) begin
    rst_last <= reset;
    en_last  <= en;
    if (!reset && en) ecount <= ecount + 1;
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_last) begin
    end else if (!en_last) begin
      chk("frz_valid", 128'(out_valid), 128'(pv));
      chk("frz_dout", 128'(d_out), 128'(pd));
    end else if (out_valid) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL stray_valid got out_valid=1 want 0");
      end else begin
        e = q.pop_front();
        chk("d_out", 128'(d_out), 128'(e.d));
        chk("out_sat", 128'(out_sat), 128'(e.s));
        chk("latency", 128'(ecount), 128'(e.due));
      end
    end
    pv <= out_valid;
    pd <= d_out;
  end

  task automatic issue(input logic [127:0] d, input logic [63:0] c,
                       input logic [5:0] sh, input logic [15:0] ed,
                       input logic es);
    exp_t e;
    en = 1'b1;
    in_valid = 1'b1;
    d_in = d;
    coef = c;
    shift = sh;
    e.d = ed;
    e.s = es;
    e.due = ecount + N + 2;
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle();
    en = 1'b1;
    in_valid = 1'b0;
    d_in = '0;
    @(negedge clk);
  endtask

  task automatic stall(input int m);
    for (int i = 0; i < m; i++) begin
      en = 1'b0;
      in_valid = 1'b1;
      d_in = {4{32'($urandom)}};
      @(negedge clk);
    end
  endtask

  task automatic model(input logic [127:0] d, input logic [63:0] c,
                       input logic [5:0] sh, output logic [15:0] o,
                       output logic s);
    longint acc;
    longint rnd;
    longint r;
    acc = 0;
    for (int k = 0; k < N; k++)
      acc += longint'($signed(d[k*16 +: 16])) * longint'($signed(c[k*8 +: 8]));
    acc = longint'($signed(acc[31:0]));
    rnd = (sh == 0) ? 64'sd0 : (64'sd1 <<< (sh - 1));
    r = (acc + rnd) >>> sh;
    if (r > 32767) begin
      o = 16'h7fff; s = 1'b1;
    end else if (r < -32768) begin
      o = 16'h8000; s = 1'b1;
    end else begin
      o = r[15:0]; s = 1'b0;
    end
  endtask

  task automatic rand_row();
    logic [127:0] d;
    logic [63:0]  c;
    logic [5:0]   sh;
    logic [15:0]  o;
    logic         s;
    for (int k = 0; k < N; k++) begin
      d[k*16 +: 16] = 16'($urandom);
      c[k*8 +: 8]   = 8'($urandom);
    end
    sh = 6'($urandom_range(0, 12));
    model(d, c, sh, o, s);
    issue(d, c, sh, o, s);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 60) begin
      idle();
      n++;
    end
    chk("drain_empty", 128'(q.size()), 128'(0));
    repeat (3) idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got no finish want finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] cb;
    reset = 1'b1;
    en = 1'b1;
    in_valid = 1'b0;
    d_in = '0;
    coef = '0;
    shift = '0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 128'(out_valid), 128'(0));
    chk("rst_dout", 128'(d_out), 128'(0));
    chk("rst_prop", 128'(prop_valid), 128'(0));
    reset = 1'b0;
    idle();

    cb = {8'sd50, -8'sd83, 8'sd89, -8'sd64,
          8'sd18, 8'sd36, -8'sd75, 8'sd64};
    issue({8{16'h0001}}, cb, 6'd0, 16'd35, 1'b0);
    chk("prop_valid", 128'(prop_valid), 128'(1));
    chk("d_prop", 128'(d_prop), {8{16'h0001}});
    issue({112'd0, 16'h0001}, 64'd64, 6'd7, 16'h0001, 1'b0);
    issue({112'd0, 16'hffff}, 64'd64, 6'd7, 16'h0000, 1'b0);
    issue({112'd0, 16'hfffe}, 64'd64, 6'd7, 16'hffff, 1'b0);
    issue({8{16'h7fff}}, {8{8'd89}}, 6'd0, 16'h7fff, 1'b1);
    issue({8{16'h8000}}, {8{8'd89}}, 6'd0, 16'h8000, 1'b1);
    drain();

    for (int i = 0; i < 16; i++) rand_row();
    drain();

    for (int i = 0; i < 10; i++) begin
      if (i == 4) stall(3);
      rand_row();
    end
    repeat (4) idle();
    stall(2);
    drain();

    for (int i = 0; i < 4; i++) rand_row();
    reset = 1'b1;
    en = 1'b0;
    in_valid = 1'b0;
    q.delete();
    @(negedge clk);
    chk("mid_rst_valid", 128'(out_valid), 128'(0));
    chk("mid_rst_dout", 128'(d_out), 128'(0));
    chk("mid_rst_sat", 128'(out_sat), 128'(0));
    chk("mid_rst_pvalid", 128'(prop_valid), 128'(0));
    chk("mid_rst_dprop", 128'(d_prop), 128'(0));
    reset = 1'b0;
    idle();
    idle();
    issue({8{16'h0002}}, cb, 6'd1, 16'd35, 1'b0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
